// File: rtl/friscv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : friscv_pkg
//  Description : Shared RV32I decode constants, formats and decoded-entry type
//  Revision    : 1.0  initial release
// ============================================================================
package friscv_pkg;

    localparam int ARCH               = 32;
    localparam int REGFILE_ADDR_WIDTH = 5;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;

    typedef enum logic [2:0] {
        FMT_R    = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_NONE = 3'd6
    } imm_fmt_t;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_state_t;

    typedef struct packed {
        logic [6:0]                    op_code;
        logic [2:0]                    func3;
        logic [6:0]                    func7;
        logic [REGFILE_ADDR_WIDTH-1:0] rs1;
        logic [REGFILE_ADDR_WIDTH-1:0] rs2;
        logic [REGFILE_ADDR_WIDTH-1:0] rd;
        logic [ARCH-1:0]               imm;
        logic                          rd_we;
        logic                          illegal;
    } decoded_t;

endpackage
`default_nettype wire

// File: rtl/imm_gen.sv
`default_nettype none
// ============================================================================
//  Module      : imm_gen
//  Description : Combinational RV32I immediate builder, sign-extended to XLEN
//  Revision    : 1.0  initial release
// ============================================================================
module imm_gen
    import friscv_pkg::*;
#(
    parameter int XLEN = ARCH
) (
    input  logic [XLEN-1:0] i_instr,
    input  imm_fmt_t        i_fmt,
    output logic [XLEN-1:0] o_imm
);

    logic [31:0] w_imm32;

    always_comb begin
        w_imm32 = 32'd0;
        case (i_fmt)
            FMT_I:   w_imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
            FMT_S:   w_imm32 = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
            FMT_B:   w_imm32 = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                                i_instr[30:25], i_instr[11:8], 1'b0};
            FMT_U:   w_imm32 = {i_instr[31:12], 12'd0};
            FMT_J:   w_imm32 = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                                i_instr[20], i_instr[30:21], 1'b0};
            default: w_imm32 = 32'd0;
        endcase
    end

    // U-type is already full width; the signed cast only matters for XLEN > 32.
    assign o_imm = XLEN'($signed(w_imm32));

endmodule
`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
//  Module      : decode_stage
//  Description : Registered RV32I decode stage with 2-entry skid buffer and
//                synchronous flush. Define DECODE_SYSTEM_EN to accept
//                SYSTEM and MISC-MEM opcodes as I-type.
//  Revision    : 1.0  initial release
// ============================================================================
module decode_stage
    import friscv_pkg::*;
#(
    parameter int XLEN      = ARCH,
    parameter int RF_ADDR_W = REGFILE_ADDR_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush_in,
    input  logic                 valid_in,
    output logic                 ready_out,
    input  logic [XLEN-1:0]      instr_in,
    input  logic [XLEN-1:0]      pc_in,
    output logic                 valid_out,
    input  logic                 ready_in,
    output logic [XLEN-1:0]      pc_out,
    output logic [6:0]           op_code_out,
    output logic [2:0]           func3_out,
    output logic [6:0]           func7_out,
    output logic [RF_ADDR_W-1:0] rs1_out,
    output logic [RF_ADDR_W-1:0] rs2_out,
    output logic [RF_ADDR_W-1:0] rd_out,
    output logic [XLEN-1:0]      imm_out,
    output logic                 rd_we_out,
    output logic                 illegal_out
);

    logic [6:0]  w_op;
    logic [2:0]  w_f3;
    logic [6:0]  w_f7;
    logic [4:0]  w_rd;
    imm_fmt_t    w_fmt;
    logic        w_illegal;
    logic        w_no_we;
    logic [XLEN-1:0] w_imm;
    decoded_t    w_dec;

    assign w_op = instr_in[6:0];
    assign w_f3 = instr_in[14:12];
    assign w_f7 = instr_in[31:25];
    assign w_rd = instr_in[11:7];

    imm_gen #(
        .XLEN (XLEN)
    ) u_imm_gen (
        .i_instr (instr_in),
        .i_fmt   (w_fmt),
        .o_imm   (w_imm)
    );

    always_comb begin
        w_fmt     = FMT_NONE;
        w_illegal = 1'b0;
        w_no_we   = 1'b0;
        case (w_op)
            OP_LUI, OP_AUIPC: w_fmt = FMT_U;
            OP_JAL:           w_fmt = FMT_J;
            OP_JALR: begin
                w_fmt     = FMT_I;
                w_illegal = (w_f3 != 3'b000);
            end
            OP_BRANCH: begin
                w_fmt     = FMT_B;
                w_illegal = (w_f3 == 3'b010) || (w_f3 == 3'b011);
            end
            OP_LOAD: begin
                w_fmt     = FMT_I;
                w_illegal = (w_f3 == 3'b011) || (w_f3 == 3'b110) || (w_f3 == 3'b111);
            end
            OP_STORE: begin
                w_fmt     = FMT_S;
                w_illegal = (w_f3 > 3'b010);
            end
            OP_IMM: begin
                w_fmt = FMT_I;
                // Shift-immediates reuse the top bits as a func7-like selector.
                if (w_f3 == 3'b001) begin
                    w_illegal = (w_f7 != F7_BASE);
                end else if (w_f3 == 3'b101) begin
                    w_illegal = (w_f7 != F7_BASE) && (w_f7 != F7_ALT);
                end
            end
            OP_REG: begin
                w_fmt     = FMT_R;
                w_illegal = ((w_f7 != F7_BASE) && (w_f7 != F7_ALT)) ||
                            ((w_f7 == F7_ALT) && (w_f3 != 3'b000) && (w_f3 != 3'b101));
            end
`ifdef DECODE_SYSTEM_EN
            OP_SYSTEM: begin
                w_fmt   = FMT_I;
                w_no_we = (w_f3 == 3'b000);
            end
            OP_FENCE: w_fmt = FMT_I;
`endif
            default: w_illegal = 1'b1;
        endcase
        if (instr_in[1:0] != 2'b11) begin
            w_illegal = 1'b1;
        end
    end

    always_comb begin
        w_dec = '0;
        if (!w_illegal) begin
            w_dec.op_code = w_op;
            w_dec.imm     = w_imm;
            case (w_fmt)
                FMT_R: begin
                    w_dec.rd    = w_rd;
                    w_dec.rs1   = instr_in[19:15];
                    w_dec.rs2   = instr_in[24:20];
                    w_dec.func3 = w_f3;
                    w_dec.func7 = w_f7;
                end
                FMT_I: begin
                    w_dec.rd    = w_rd;
                    w_dec.rs1   = instr_in[19:15];
                    w_dec.func3 = w_f3;
                end
                FMT_S, FMT_B: begin
                    w_dec.rs1   = instr_in[19:15];
                    w_dec.rs2   = instr_in[24:20];
                    w_dec.func3 = w_f3;
                end
                FMT_U, FMT_J: w_dec.rd = w_rd;
                default: ;
            endcase
            w_dec.rd_we = ((w_fmt == FMT_R) || (w_fmt == FMT_I) ||
                           (w_fmt == FMT_U) || (w_fmt == FMT_J)) &&
                          (w_rd != 5'd0) && !w_no_we;
        end
        w_dec.illegal = w_illegal;
    end

    occ_state_t      state_q, state_d;
    decoded_t        main_q, main_d, skid_q, skid_d;
    logic [XLEN-1:0] main_pc_q, main_pc_d, skid_pc_q, skid_pc_d;
    logic            ready_q, ready_d;
    logic            w_accept;
    logic            w_xfer;

    assign w_accept = valid_in && ready_q;
    assign w_xfer   = (state_q != OCC_EMPTY) && ready_in;

    always_comb begin
        state_d   = state_q;
        main_d    = main_q;
        main_pc_d = main_pc_q;
        skid_d    = skid_q;
        skid_pc_d = skid_pc_q;
        if (flush_in) begin
            state_d = OCC_EMPTY;
        end else begin
            case (state_q)
                OCC_EMPTY: begin
                    if (w_accept) begin
                        main_d    = w_dec;
                        main_pc_d = pc_in;
                        state_d   = OCC_ONE;
                    end
                end
                OCC_ONE: begin
                    if (w_accept && !w_xfer) begin
                        skid_d    = w_dec;
                        skid_pc_d = pc_in;
                        state_d   = OCC_TWO;
                    end else if (w_accept && w_xfer) begin
                        main_d    = w_dec;
                        main_pc_d = pc_in;
                    end else if (w_xfer) begin
                        state_d   = OCC_EMPTY;
                    end
                end
                OCC_TWO: begin
                    if (w_xfer) begin
                        main_d    = skid_q;
                        main_pc_d = skid_pc_q;
                        state_d   = OCC_ONE;
                    end
                end
                default: state_d = OCC_EMPTY;
            endcase
        end
        // Registered ready tracks the next skid occupancy.
        ready_d = (state_d != OCC_TWO);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= OCC_EMPTY;
            main_q    <= '0;
            main_pc_q <= '0;
            skid_q    <= '0;
            skid_pc_q <= '0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            main_q    <= main_d;
            main_pc_q <= main_pc_d;
            skid_q    <= skid_d;
            skid_pc_q <= skid_pc_d;
            ready_q   <= ready_d;
        end
    end

    assign ready_out   = ready_q;
    assign valid_out   = (state_q != OCC_EMPTY);
    assign pc_out      = main_pc_q;
    assign op_code_out = main_q.op_code;
    assign func3_out   = main_q.func3;
    assign func7_out   = main_q.func7;
    assign rs1_out     = main_q.rs1;
    assign rs2_out     = main_q.rs2;
    assign rd_out      = main_q.rd;
    assign imm_out     = main_q.imm;
    assign rd_we_out   = main_q.rd_we;
    assign illegal_out = main_q.illegal;

endmodule
`default_nettype wire
